// File: rtl/dm_ctrl.sv
// Data-memory controller: word array with byte/half/word access, valid/ready handshake,
// configurable latency and post-reset clear. Optional store trace under `DM_TRACE_EN`.
module dm_ctrl #(
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned RD_LAT    = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_freeze,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_width,
    input  logic        i_req_sign,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [31:0] i_req_pc,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_exc,
    output logic [1:0]  o_rsp_exc_code
);

    localparam int unsigned Depth      = 2 ** ADDR_BITS;
    localparam logic [1:0]  CntInit    = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;
    localparam logic [32:0] RangeLimit = 33'(Depth) << 2;

    typedef enum logic [1:0] {StClear, StIdle, StBusy, StResp} state_e;

    state_e                 r_state, w_state_next;
    logic [ADDR_BITS-1:0]   r_clr_idx;
    logic [1:0]             r_cnt;
    logic                   r_req_we;
    logic [2:0]             r_req_width;
    logic                   r_req_sign;
    logic [31:0]            r_req_addr;
    logic [31:0]            r_req_wdata;
    logic [31:0]            r_req_pc;
    logic [31:0]            r_rdata;
    logic                   r_exc;
    logic [1:0]             r_exc_code;
    logic [31:0]            r_mem [Depth];

    logic                   w_accept;
    logic                   w_enter_resp;
    logic                   w_cur_we;
    logic [2:0]             w_cur_width;
    logic                   w_cur_sign;
    logic [31:0]            w_cur_addr;
    logic [31:0]            w_cur_wdata;
    logic [31:0]            w_cur_pc;
    logic [31:0]            w_off;
    logic [ADDR_BITS-1:0]   w_idx;
    logic [1:0]             w_lane;
    logic [31:0]            w_old;
    logic [15:0]            w_shifted;
    logic [1:0]             w_exc_code;
    logic [3:0]             w_byte_en;
    logic [31:0]            w_wdata_pos;
    logic [31:0]            w_merged;
    logic [31:0]            w_load;

    assign o_req_ready    = (r_state == StIdle) && !i_freeze;
    assign o_rsp_valid    = (r_state == StResp);
    assign o_rsp_rdata    = r_rdata;
    assign o_rsp_exc      = r_exc;
    assign o_rsp_exc_code = r_exc_code;

    assign w_accept = o_req_ready && i_req_valid;

    // With RD_LAT==1 the access happens on the accept edge, so use the live request in IDLE.
    assign w_cur_we    = (r_state == StIdle) ? i_req_we    : r_req_we;
    assign w_cur_width = (r_state == StIdle) ? i_req_width : r_req_width;
    assign w_cur_sign  = (r_state == StIdle) ? i_req_sign  : r_req_sign;
    assign w_cur_addr  = (r_state == StIdle) ? i_req_addr  : r_req_addr;
    assign w_cur_wdata = (r_state == StIdle) ? i_req_wdata : r_req_wdata;
    assign w_cur_pc    = (r_state == StIdle) ? i_req_pc    : r_req_pc;

    assign w_off     = w_cur_addr - BASE_ADDR;
    assign w_idx     = w_off[ADDR_BITS+1:2];
    assign w_lane    = w_off[1:0];
    assign w_old     = r_mem[w_idx];
    assign w_shifted = 16'(w_old >> {w_lane, 3'b000});

    always_comb begin
        w_exc_code = 2'd0;
        if (!(w_cur_width == 3'd1 || w_cur_width == 3'd2 || w_cur_width == 3'd4)) begin
            w_exc_code = 2'd3;
        end else if ((w_cur_width == 3'd2 && w_off[0]) ||
                     (w_cur_width == 3'd4 && w_off[1:0] != 2'b00)) begin
            w_exc_code = 2'd1;
        end else if ({1'b0, w_off} >= RangeLimit) begin
            w_exc_code = 2'd2;
        end
    end

    always_comb begin
        w_byte_en   = 4'b0000;
        w_wdata_pos = w_cur_wdata;
        w_load      = 32'd0;
        case (w_cur_width)
            3'd4: begin
                w_byte_en = 4'b1111;
                w_load    = w_old;
            end
            3'd2: begin
                w_byte_en   = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata_pos = {2{w_cur_wdata[15:0]}};
                w_load      = {{16{w_cur_sign & w_shifted[15]}}, w_shifted};
            end
            3'd1: begin
                w_byte_en   = 4'b0001 << w_lane;
                w_wdata_pos = {4{w_cur_wdata[7:0]}};
                w_load      = {{24{w_cur_sign & w_shifted[7]}}, w_shifted[7:0]};
            end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) begin
            w_merged[i*8 +: 8] = w_byte_en[i] ? w_wdata_pos[i*8 +: 8] : w_old[i*8 +: 8];
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StClear: if (&r_clr_idx) w_state_next = StIdle;
            StIdle:  if (i_req_valid) w_state_next = (RD_LAT == 1) ? StResp : StBusy;
            StBusy:  if (r_cnt == 2'd0) w_state_next = StResp;
            StResp:  w_state_next = StIdle;
            default: w_state_next = StClear;
        endcase
        if (i_freeze) w_state_next = r_state;
    end

    assign w_enter_resp = !i_freeze && (w_state_next == StResp) && (r_state != StResp);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= StClear;
            r_clr_idx   <= '0;
            r_cnt       <= 2'd0;
            r_req_we    <= 1'b0;
            r_req_width <= 3'd0;
            r_req_sign  <= 1'b0;
            r_req_addr  <= 32'd0;
            r_req_wdata <= 32'd0;
            r_req_pc    <= 32'd0;
            r_rdata     <= 32'd0;
            r_exc       <= 1'b0;
            r_exc_code  <= 2'd0;
        end else if (!i_freeze) begin
            r_state <= w_state_next;
            if (r_state == StClear) r_clr_idx <= r_clr_idx + ADDR_BITS'(1);
            if (w_accept) begin
                r_req_we    <= i_req_we;
                r_req_width <= i_req_width;
                r_req_sign  <= i_req_sign;
                r_req_addr  <= i_req_addr;
                r_req_wdata <= i_req_wdata;
                r_req_pc    <= i_req_pc;
                r_cnt       <= CntInit;
            end else if (r_state == StBusy) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_enter_resp) begin
                r_rdata    <= (w_exc_code != 2'd0 || w_cur_we) ? 32'd0 : w_load;
                r_exc      <= (w_exc_code != 2'd0);
                r_exc_code <= w_exc_code;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset && !i_freeze) begin
            if (r_state == StClear) begin
                r_mem[r_clr_idx] <= 32'd0;
            end else if (w_enter_resp && w_cur_we && w_exc_code == 2'd0) begin
                r_mem[w_idx] <= w_merged;
            end
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge i_clk) begin
        if (i_reset && w_enter_resp && w_cur_we && w_exc_code == 2'd0) begin
            $display("%d@%h: *%h <= %h", $time, w_cur_pc, {w_cur_addr[31:2], 2'b00}, w_merged);
        end
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^w_cur_pc;
`endif

endmodule
